// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester's access channel into data_mem_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, done, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU and DBG requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; the default build uses fixed CPU priority.
module data_mem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave cpu,
    data_mem_arbiter_if.slave dbg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic              mem_on,
    output logic              busy
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              owner_r, owner_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              cpu_gnt_r, cpu_gnt_s, dbg_gnt_r, dbg_gnt_s;
    logic              cpu_done_r, cpu_done_s, dbg_done_r, dbg_done_s;
    logic [DATA_W-1:0] cpu_rdata_r, cpu_rdata_s, dbg_rdata_r, dbg_rdata_s;
    logic              mem_on_r, mem_on_s, mem_wr_r, mem_wr_s, busy_r, busy_s;
    logic              pick_dbg_s;

    // Winner selection among the currently raised requests
    always_comb begin
        pick_dbg_s = 1'b0;
        if (cpu.req && dbg.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_dbg_s = (owner_r == OWN_CPU);
`else
            pick_dbg_s = 1'b0;
`endif
        end else begin
            pick_dbg_s = dbg.req;
        end
    end

    // Next-state and next-output logic of the access sequencer
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        owner_s     = owner_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        cpu_gnt_s   = 1'b0;
        dbg_gnt_s   = 1'b0;
        cpu_done_s  = 1'b0;
        dbg_done_s  = 1'b0;
        cpu_rdata_s = cpu_rdata_r;
        dbg_rdata_s = dbg_rdata_r;
        mem_on_s    = 1'b0;
        mem_wr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu.req || dbg.req) begin
                    owner_s = pick_dbg_s ? OWN_DBG : OWN_CPU;
                    we_s    = pick_dbg_s ? dbg.we : cpu.we;
                    addr_s  = pick_dbg_s ? dbg.addr : cpu.addr;
                    wdata_s = pick_dbg_s ? dbg.wdata : cpu.wdata;
                    cpu_gnt_s = ~pick_dbg_s;
                    dbg_gnt_s = pick_dbg_s;
                    cnt_s     = CNT_LOAD;
                    state_s   = ST_ACCESS;
                    mem_on_s  = 1'b1;
                    mem_wr_s  = we_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s    = ST_DONE;
                    cpu_done_s = (owner_r == OWN_CPU);
                    dbg_done_s = (owner_r == OWN_DBG);
                    // Read data is captured on the edge that ends the access
                    if (!we_r && owner_r == OWN_CPU) begin
                        cpu_rdata_s = mem_rdata;
                    end else if (!we_r) begin
                        dbg_rdata_s = mem_rdata;
                    end else begin
                        cpu_rdata_s = cpu_rdata_r;
                    end
                end else begin
                    cnt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    mem_on_s = 1'b1;
                    mem_wr_s = we_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            owner_r     <= OWN_DBG;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            cpu_gnt_r   <= 1'b0;
            dbg_gnt_r   <= 1'b0;
            cpu_done_r  <= 1'b0;
            dbg_done_r  <= 1'b0;
            cpu_rdata_r <= {DATA_W{1'b0}};
            dbg_rdata_r <= {DATA_W{1'b0}};
            mem_on_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            owner_r     <= owner_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            cpu_gnt_r   <= cpu_gnt_s;
            dbg_gnt_r   <= dbg_gnt_s;
            cpu_done_r  <= cpu_done_s;
            dbg_done_r  <= dbg_done_s;
            cpu_rdata_r <= cpu_rdata_s;
            dbg_rdata_r <= dbg_rdata_s;
            mem_on_r    <= mem_on_s;
            mem_wr_r    <= mem_wr_s;
            busy_r      <= busy_s;
        end
    end

    assign cpu.gnt   = cpu_gnt_r;
    assign cpu.done  = cpu_done_r;
    assign cpu.rdata = cpu_rdata_r;
    assign dbg.gnt   = dbg_gnt_r;
    assign dbg.done  = dbg_done_r;
    assign dbg.rdata = dbg_rdata_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wr    = mem_wr_r;
    assign mem_on    = mem_on_r;
    assign busy      = busy_r;
endmodule
